ddr3_traffic_checker: RTL
=========================

Name: ddr3_traffic_checker

Overview:
Parametrised, self-checking traffic generator that drives the user-side port of ddr3_memory_controller. It replaces the free-running incrementing stimulus plus all-ones "done" detection with a programmable sequence: a write phase over a configurable address window, then a read-back phase. Read-back data is compared against a regenerated expected pattern, and the block reports done, pass, an error count and the first failing address. It sits between the host test logic and ddr3_memory_controller.

Parameters:
ADDRESS_BITWIDTH, 13, DDR row/column address width (15 for 4GB parts)
BANK_ADDRESS_BITWIDTH, 4, bank address width
DQ_BITWIDTH, 8, user data word width (16 for x16 parts)
NUM_WORDS, 256, number of words written then read per pass; must be ≥1
START_ADDRESS, 0, first user address of the test window
MAX_OUTSTANDING, 4, maximum read requests in flight; must be ≥1
ERR_COUNT_BITWIDTH, 16, error counter width

Ports:
clk  input  1  host clock
reset  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a pass; honoured only in IDLE or DONE
mode  input  2  pattern: 0 incrementing, 1 walking-one, 2 LFSR, 3 alternating ones/zeros; sampled on start
ctrl_ready  input  1  controller accepts a write/read request this cycle
write_enable  output  1  write request valid
read_enable  output  1  read request valid
i_user_data_address  output  BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH  request address
i_user_data  output  DQ_BITWIDTH  write data
o_user_data  input  DQ_BITWIDTH  read data from controller
o_user_data_valid  input  1  o_user_data valid; returns in request order
busy  output  1  high in every state except IDLE and DONE
done  output  1  level; high in DONE until next start or reset
pass  output  1  done && (err_count == 0)
err_count  output  ERR_COUNT_BITWIDTH  mismatches, saturating at all-ones
first_err_address  output  BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH  address of first mismatch; 0 if none

Behaviour:
- Reset: state IDLE; all outputs 0; index, outstanding and error counters cleared. A reset mid-pass abandons the pass, and o_user_data_valid pulses arriving after reset are ignored.
- Word index i runs 0..NUM_WORDS-1. Address = START_ADDRESS + i, truncated to address width, so the window wraps modulo 2^(total width).
- Handshake: a request is held (valid, address and data stable) until accepted on a cycle where enable && ctrl_ready; write_enable and read_enable are never high together.
- FSM: IDLE -start-> WRITE.
- WRITE issues words 0..NUM_WORDS-1; the accept of the last word -> READ.
- READ issues read requests while outstanding < MAX_OUTSTANDING. Outstanding increments on accept and decrements on o_user_data_valid; simultaneous accept and return leaves it unchanged. After the last read is accepted -> DRAIN.
- DRAIN -> DONE when outstanding returns to 0.
- DONE -start-> WRITE, which clears err_count, first_err_address and index for the new pass.
- Checking: a separate check index regenerates the expected word on each o_user_data_valid. On mismatch, err_count increments (saturating), and first_err_address latches only on the first error of the pass.
- Unexpected data: o_user_data_valid with outstanding == 0 in READ or DRAIN counts one error, with no compare and no first-address capture. It is ignored in IDLE and DONE.
- Patterns for word i:
  - mode 0: i[DQ_BITWIDTH-1:0]
  - mode 1: 1 << (i mod DQ_BITWIDTH)
  - mode 2: LFSR state
  - mode 3: all-ones when i is even, all-zeros when i is odd
- LFSR: 32-bit Fibonacci, polynomial x^32+x^22+x^2+x+1, seed 32'hACE1_1234 at word 0, one step per word; data = low DQ_BITWIDTH bits. Write and check generators are separate instances with identical seeds.
- start while busy is ignored. mode is latched on accepted start only.

Optional Feature:
TRAFFIC_LFSR_EN: when defined, mode 2 produces the LFSR pattern as above. When undefined, no LFSR logic is built and mode 2 behaves exactly as mode 0.

Test Plan:
1. Ideal loopback model, ctrl_ready=1, mode=0, NUM_WORDS=256 -> 256 writes with data 0x00..0xFF, then 256 reads; done=1, pass=1, err_count=0.
2. Model corrupts the word at address 0x0005 (bit 0 flipped), mode=1 -> err_count=1, first_err_address=0x0005, pass=0.
3. ctrl_ready toggled pseudo-randomly, MAX_OUTSTANDING=4 -> no dropped or duplicated requests, outstanding never exceeds 4, pass=1.
4. START_ADDRESS = max address - 1, NUM_WORDS=4 -> addresses max-1, max, 0, 1; pass=1.
5. Reset asserted mid-READ with 3 reads outstanding -> next cycle busy=0, all outputs 0; late valids ignored; next start gives pass=1.
6. mode=2 with TRAFFIC_LFSR_EN defined -> first written word = 0x34 (DQ=8); without the macro -> first word 0x00.

Source files
------------

// File: rtl/ddr3_traffic_checker.sv
// Write-then-read-back traffic generator and checker for the ddr3_memory_controller user port.
// Define TRAFFIC_LFSR_EN to build the LFSR pattern (mode 2); otherwise mode 2 behaves like mode 0.
module ddr3_traffic_checker #(
    parameter int ADDRESS_BITWIDTH      = 13,
    parameter int BANK_ADDRESS_BITWIDTH = 4,
    parameter int DQ_BITWIDTH           = 8,
    parameter int NUM_WORDS             = 256,
    parameter int START_ADDRESS         = 0,
    parameter int MAX_OUTSTANDING       = 4,
    parameter int ERR_COUNT_BITWIDTH    = 16
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              start,
    input  logic [1:0]                                        mode,
    input  logic                                              ctrl_ready,
    output logic                                              write_enable,
    output logic                                              read_enable,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
    output logic [DQ_BITWIDTH-1:0]                            i_user_data,
    input  logic [DQ_BITWIDTH-1:0]                            o_user_data,
    input  logic                                              o_user_data_valid,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              pass,
    output logic [ERR_COUNT_BITWIDTH-1:0]                     err_count,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_err_address
);

    localparam int AW    = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS + 1) : 1;
    localparam int OW    = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [AW-1:0]    START_ADDR = AW'(START_ADDRESS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_WORDS - 1);
    localparam logic [OW-1:0]    MAX_OUT    = OW'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        chk_idx;
    logic [OW-1:0]           outstanding;
    logic [1:0]              mode_q;
    logic                    have_err;
    logic                    start_ok;
    logic                    accept_wr;
    logic                    accept_rd;
    logic                    rsp_live;
    logic                    rsp_expected;
    logic                    rsp_unexpected;
    logic                    mismatch;
    logic [DQ_BITWIDTH-1:0]  wr_data;
    logic [DQ_BITWIDTH-1:0]  exp_data;

    function automatic logic [DQ_BITWIDTH-1:0] pattern(input logic [1:0] m, input logic [IDX_W-1:0] i);
        logic [DQ_BITWIDTH-1:0] p;
        case (m)
            2'd1:    p = DQ_BITWIDTH'(1) << (32'(i) % DQ_BITWIDTH);
            2'd3:    p = i[0] ? '0 : '1;
            default: p = DQ_BITWIDTH'(i);
        endcase
        return p;
    endfunction

    function automatic logic [ERR_COUNT_BITWIDTH-1:0] sat_inc(input logic [ERR_COUNT_BITWIDTH-1:0] v);
        return (&v) ? v : v + ERR_COUNT_BITWIDTH'(1);
    endfunction

    assign start_ok       = start && (state == S_IDLE || state == S_DONE);
    assign accept_wr      = write_enable && ctrl_ready;
    assign accept_rd      = read_enable && ctrl_ready;
    assign rsp_live       = o_user_data_valid && (state == S_READ || state == S_DRAIN);
    assign rsp_expected   = rsp_live && (outstanding != '0);
    assign rsp_unexpected = rsp_live && (outstanding == '0);
    assign mismatch       = rsp_expected && (o_user_data != exp_data);

`ifdef TRAFFIC_LFSR_EN
    // Write and check generators advance independently: one per accepted write, one per checked return.
    localparam logic [31:0] LFSR_SEED = 32'hACE1_1234;

    logic [31:0] lfsr_wr;
    logic [31:0] lfsr_chk;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            lfsr_wr  <= LFSR_SEED;
            lfsr_chk <= LFSR_SEED;
        end else begin
            if (accept_wr)    lfsr_wr  <= lfsr_step(lfsr_wr);
            if (rsp_expected) lfsr_chk <= lfsr_step(lfsr_chk);
        end
    end

    assign wr_data  = (mode_q == 2'd2) ? lfsr_wr[DQ_BITWIDTH-1:0]  : pattern(mode_q, idx);
    assign exp_data = (mode_q == 2'd2) ? lfsr_chk[DQ_BITWIDTH-1:0] : pattern(mode_q, chk_idx);
`else
    assign wr_data  = pattern(mode_q, idx);
    assign exp_data = pattern(mode_q, chk_idx);
`endif

    always_comb begin
        state_next   = state;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_next = S_WRITE;
            end
            S_WRITE: begin
                write_enable = 1'b1;
                if (ctrl_ready && idx == LAST_IDX) state_next = S_READ;
            end
            S_READ: begin
                // Only raised when a slot is free, so it cannot drop before acceptance.
                read_enable = (outstanding < MAX_OUT);
                if (read_enable && ctrl_ready && idx == LAST_IDX) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (outstanding == '0) state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            idx               <= '0;
            chk_idx           <= '0;
            outstanding       <= '0;
            mode_q            <= '0;
            have_err          <= 1'b0;
            err_count         <= '0;
            first_err_address <= '0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                mode_q            <= mode;
                idx               <= '0;
                chk_idx           <= '0;
                have_err          <= 1'b0;
                err_count         <= '0;
                first_err_address <= '0;
            end else begin
                if (accept_wr)
                    idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                else if (accept_rd)
                    idx <= idx + IDX_W'(1);
                if (rsp_expected)
                    chk_idx <= chk_idx + IDX_W'(1);
                if (mismatch || rsp_unexpected)
                    err_count <= sat_inc(err_count);
                if (mismatch && !have_err) begin
                    have_err          <= 1'b1;
                    first_err_address <= START_ADDR + AW'(chk_idx);
                end
            end
            case ({accept_rd, rsp_expected})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: ;
            endcase
        end
    end

    assign i_user_data_address = (state == S_WRITE || state == S_READ) ? START_ADDR + AW'(idx) : '0;
    assign i_user_data         = (state == S_WRITE) ? wr_data : '0;
    assign busy                = !(state == S_IDLE || state == S_DONE);
    assign done                = (state == S_DONE);
    assign pass                = done && (err_count == '0);

endmodule
